// File: rtl/ps2_rx_byte.sv
// ps2_rx_byte: PS/2 device-to-host receiver (sync, clock glitch filter, 11-bit framing, timeout).
// Define PS2_RX_PARITY_EN to drop frames with a bad odd-parity bit; otherwise parity is ignored.
module ps2_rx_byte #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t          state;
  logic            clk_s1, clk_s2, dat_s1, dat_s2, filt, filt_d, par_bad;
  logic [FW-1:0]   fcnt;
  logic [TW-1:0]   tcnt;
  logic [7:0]      shreg;
  logic [2:0]      bcnt;
  logic            fall, timeout;
  assign fall    = filt_d & ~filt;
  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));
  assign busy    = state != IDLE;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      {clk_s1, clk_s2, dat_s1, dat_s2, filt, filt_d} <= '1;
      fcnt             <= '0;
      tcnt             <= '0;
      state            <= IDLE;
      shreg            <= '0;
      bcnt             <= '0;
      par_bad          <= 1'b0;
      received_data    <= '0;
      received_data_en <= 1'b0;
      parity_err       <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      clk_s1           <= ps2_clk;
      clk_s2           <= clk_s1;
      dat_s1           <= ps2_dat;
      dat_s2           <= dat_s1;
      filt_d           <= filt;
      received_data_en <= 1'b0;
      parity_err       <= 1'b0;
      frame_err        <= 1'b0;
      // filtered level only moves after FILTER_LEN consecutive disagreeing samples
      if (clk_s2 == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= ~filt;
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
      tcnt <= (state == IDLE || fall) ? '0 : (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE: if (!dat_s2) begin
            state <= DATA;
            bcnt  <= '0;
          end
          DATA: begin
            shreg[bcnt] <= dat_s2;
            bcnt        <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
`ifdef PS2_RX_PARITY_EN
            par_bad <= ~^{shreg, dat_s2};
`else
            par_bad <= 1'b0;
`endif
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!dat_s2) frame_err <= 1'b1;
            else if (par_bad) parity_err <= 1'b1;
            else begin
              received_data    <= shreg;
              received_data_en <= 1'b1;
            end
          end
        endcase
      end else if (timeout) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end
    end
  end
endmodule
